// File: rtl/ed25519_sign_dispatch.sv
// ed25519_sign_dispatch
// Multi-channel front end for a shared Ed25519 signer engine. Requests from
// NUM_CH clients (full key or threshold shard) are granted round-robin, issued
// to the engine, supervised with a timeout, and answered with a tagged
// signature or error. Key material lives only while a job is in flight.
//
// Ports:
//   clk, reset            clock, asynchronous active-high reset
//   req_valid/req_ready   per-channel request handshake (one grant max)
//   req_partial           per-channel mode, 1 = partial-shard signing
//   req_key, req_hash     per-channel key/shard and hash, channel i at [i*W +: W]
//   eng_start, eng_abort  one-cycle pulses to the engine
//   eng_partial/key/hash  job operands, stable from start to done
//   eng_done, eng_sig     engine completion pulse and signature
//   rsp_valid/rsp_ready   response handshake
//   rsp_ch, rsp_partial   originating channel and job mode
//   rsp_sig, rsp_err      signature (zero on error), 1 = timeout abort
//   busy                  high whenever a job is held (not IDLE)
module ed25519_sign_dispatch #(
   parameter int NUM_CH      = 4,
   parameter int KEY_W       = 256,
   parameter int HASH_W      = 128,
   parameter int SIG_W       = 256,
   parameter int TIMEOUT_CYC = 4096,
   localparam int CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic [NUM_CH-1:0]        req_valid,
   output logic [NUM_CH-1:0]        req_ready,
   input  logic [NUM_CH-1:0]        req_partial,
   input  logic [NUM_CH*KEY_W-1:0]  req_key,
   input  logic [NUM_CH*HASH_W-1:0] req_hash,
   output logic                     eng_start,
   output logic                     eng_partial,
   output logic [KEY_W-1:0]         eng_key,
   output logic [HASH_W-1:0]        eng_hash,
   output logic                     eng_abort,
   input  logic                     eng_done,
   input  logic [SIG_W-1:0]         eng_sig,
   output logic                     rsp_valid,
   input  logic                     rsp_ready,
   output logic [CH_W-1:0]          rsp_ch,
   output logic                     rsp_partial,
   output logic [SIG_W-1:0]         rsp_sig,
   output logic                     rsp_err,
   output logic                     busy
);

   localparam int TIMER_W = $clog2(TIMEOUT_CYC);
   localparam int SCAN_W  = CH_W + 1;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ISSUE = 2'd1,
      S_WAIT  = 2'd2,
      S_RESP  = 2'd3
   } state_t;

   state_t              state, state_nxt;
   logic [CH_W-1:0]     rr_ptr;
   logic                grant_vld;
   logic [CH_W-1:0]     grant_ch;
   logic [SCAN_W-1:0]   scan_idx;

   logic [KEY_W-1:0]    key_q;
   logic [HASH_W-1:0]   hash_q;
   logic                partial_q;
   logic [CH_W-1:0]     ch_q;
   logic [SIG_W-1:0]    sig_q;
   logic                err_q;
   logic [TIMER_W-1:0]  timer_q;

   logic                do_grant;
   logic                wait_done;
   logic                wait_tmo;
   logic                rsp_fire;
   logic                tmo_hit;

   logic [KEY_W-1:0]    key_arr  [NUM_CH];
   logic [HASH_W-1:0]   hash_arr [NUM_CH];

   for (genvar i = 0; i < NUM_CH; i++) begin : g_unpack
      assign key_arr[i]  = req_key[i*KEY_W +: KEY_W];
      assign hash_arr[i] = req_hash[i*HASH_W +: HASH_W];
   end

   // Round-robin scan: first valid channel at or after rr_ptr, wrapping.
   always_comb begin
      grant_vld = 1'b0;
      grant_ch  = '0;
      scan_idx  = '0;
      for (int k = 0; k < NUM_CH; k++) begin
         scan_idx = {1'b0, rr_ptr} + SCAN_W'(k);
         if (scan_idx >= SCAN_W'(NUM_CH))
            scan_idx = scan_idx - SCAN_W'(NUM_CH);
         if (!grant_vld && req_valid[scan_idx[CH_W-1:0]]) begin
            grant_vld = 1'b1;
            grant_ch  = scan_idx[CH_W-1:0];
         end
      end
   end

   assign tmo_hit = (timer_q == TIMER_W'(TIMEOUT_CYC - 1));

   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         state <= S_IDLE;
      else
         state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      req_ready = '0;
      eng_start = 1'b0;
      eng_abort = 1'b0;
      do_grant  = 1'b0;
      wait_done = 1'b0;
      wait_tmo  = 1'b0;
      rsp_fire  = 1'b0;
      case (state)
         S_IDLE: begin
            // Gated by reset so no grant is signalled while reset is held.
            if (grant_vld && !reset) begin
               req_ready = NUM_CH'(1) << grant_ch;
               do_grant  = 1'b1;
               state_nxt = S_ISSUE;
            end
         end
         S_ISSUE: begin
            eng_start = 1'b1;
            state_nxt = S_WAIT;
         end
         S_WAIT: begin
            // A done arriving on the terminal timer cycle wins over the abort.
            if (eng_done) begin
               wait_done = 1'b1;
               state_nxt = S_RESP;
            end else if (tmo_hit) begin
               wait_tmo  = 1'b1;
               eng_abort = 1'b1;
               state_nxt = S_RESP;
            end
         end
         S_RESP: begin
            if (rsp_ready) begin
               rsp_fire  = 1'b1;
               state_nxt = S_IDLE;
            end
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rr_ptr    <= '0;
         key_q     <= '0;
         hash_q    <= '0;
         partial_q <= 1'b0;
         ch_q      <= '0;
         sig_q     <= '0;
         err_q     <= 1'b0;
         timer_q   <= '0;
      end else begin
         if (do_grant) begin
            key_q     <= key_arr[grant_ch];
            hash_q    <= hash_arr[grant_ch];
            partial_q <= req_partial[grant_ch];
            ch_q      <= grant_ch;
            rr_ptr    <= (grant_ch == CH_W'(NUM_CH - 1)) ? '0 : grant_ch + CH_W'(1);
         end
         if (state == S_ISSUE)
            timer_q <= '0;
         if (state == S_WAIT)
            timer_q <= timer_q + TIMER_W'(1);
         // Key material is wiped the moment the engine no longer needs it.
         if (wait_done) begin
            sig_q <= eng_sig;
            err_q <= 1'b0;
            key_q <= '0;
         end else if (wait_tmo) begin
            sig_q <= '0;
            err_q <= 1'b1;
            key_q <= '0;
         end
         if (rsp_fire) begin
            sig_q  <= '0;
            hash_q <= '0;
            err_q  <= 1'b0;
         end
      end
   end

   assign eng_partial = partial_q;
   assign eng_key     = key_q;
   assign eng_hash    = hash_q;
   assign rsp_valid   = (state == S_RESP);
   assign rsp_ch      = ch_q;
   assign rsp_partial = partial_q;
   assign rsp_sig     = sig_q;
   assign rsp_err     = err_q;
   assign busy        = (state != S_IDLE);

endmodule

// File: tb/tb_ed25519_sign_dispatch.sv
module tb_ed25519_sign_dispatch;

   localparam int NUM_CH      = 4;
   localparam int KEY_W       = 256;
   localparam int HASH_W      = 128;
   localparam int SIG_W       = 256;
   localparam int TIMEOUT_CYC = 16;
   localparam int CH_W        = 2;

   localparam logic [KEY_W-1:0] KEY_A5 = {32{8'hA5}};
   localparam logic [KEY_W-1:0] KEY_77 = {32{8'h77}};
   localparam logic [SIG_W-1:0] SIG_T1 = {16'hDEAD, 224'h0, 16'hBEEF};
   localparam logic [SIG_W-1:0] SIG_P  = {32{8'h3C}};
   localparam logic [SIG_W-1:0] SIG_C  = {64{4'hC}};

   logic                     clk = 1'b0;
   logic                     reset;
   logic [NUM_CH-1:0]        req_valid;
   logic [NUM_CH-1:0]        req_ready;
   logic [NUM_CH-1:0]        req_partial;
   logic [NUM_CH*KEY_W-1:0]  req_key;
   logic [NUM_CH*HASH_W-1:0] req_hash;
   logic                     eng_start;
   logic                     eng_partial;
   logic [KEY_W-1:0]         eng_key;
   logic [HASH_W-1:0]        eng_hash;
   logic                     eng_abort;
   logic                     eng_done;
   logic [SIG_W-1:0]         eng_sig;
   logic                     rsp_valid;
   logic                     rsp_ready;
   logic [CH_W-1:0]          rsp_ch;
   logic                     rsp_partial;
   logic [SIG_W-1:0]         rsp_sig;
   logic                     rsp_err;
   logic                     busy;

   int checks   = 0;
   int failures = 0;

   ed25519_sign_dispatch #(
      .NUM_CH(NUM_CH), .KEY_W(KEY_W), .HASH_W(HASH_W),
      .SIG_W(SIG_W), .TIMEOUT_CYC(TIMEOUT_CYC)
   ) dut (
      .clk(clk), .reset(reset),
      .req_valid(req_valid), .req_ready(req_ready), .req_partial(req_partial),
      .req_key(req_key), .req_hash(req_hash),
      .eng_start(eng_start), .eng_partial(eng_partial), .eng_key(eng_key),
      .eng_hash(eng_hash), .eng_abort(eng_abort), .eng_done(eng_done),
      .eng_sig(eng_sig),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_ch(rsp_ch),
      .rsp_partial(rsp_partial), .rsp_sig(rsp_sig), .rsp_err(rsp_err),
      .busy(busy)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick;
      @(negedge clk);
      #1;
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_req_ready"}, req_ready, 0);
      chk({tag, "_eng_start"}, eng_start, 0);
      chk({tag, "_eng_partial"}, eng_partial, 0);
      chk({tag, "_eng_key"}, eng_key, 0);
      chk({tag, "_eng_hash"}, eng_hash, 0);
      chk({tag, "_eng_abort"}, eng_abort, 0);
      chk({tag, "_rsp_valid"}, rsp_valid, 0);
      chk({tag, "_rsp_ch"}, rsp_ch, 0);
      chk({tag, "_rsp_partial"}, rsp_partial, 0);
      chk({tag, "_rsp_sig"}, rsp_sig, 0);
      chk({tag, "_rsp_err"}, rsp_err, 0);
      chk({tag, "_busy"}, busy, 0);
   endtask

   function automatic logic [KEY_W-1:0] key_of(input int i);
      logic [7:0] b;
      b = 8'h10 + 8'(i);
      return {32{b}};
   endfunction

   initial begin
      int   n;
      logic seen_rsp;

      reset = 1'b0; req_valid = '0; req_partial = '0; req_key = '0; req_hash = '0;
      eng_done = 1'b0; eng_sig = '0; rsp_ready = 1'b0;
      #2;
      // Reset with a request pending: nothing may be granted.
      reset = 1'b1;
      req_valid = 4'b0001;
      tick;
      chk_all_zero("reset");
      req_valid = '0;
      reset = 1'b0;
      tick;

      // Single full-key job on channel 2.
      req_key[2*KEY_W +: KEY_W]    = KEY_A5;
      req_hash[2*HASH_W +: HASH_W] = 128'h1234;
      req_valid = 4'b0100;
      #1;
      chk("t1_ready", req_ready, 4'b0100);
      tick;
      req_valid = '0;
      chk("t1_start", eng_start, 1);
      chk("t1_eng_key", eng_key, KEY_A5);
      chk("t1_eng_hash", eng_hash, 128'h1234);
      chk("t1_eng_partial", eng_partial, 0);
      chk("t1_busy", busy, 1);
      tick;
      chk("t1_start_pulse", eng_start, 0);
      repeat (9) tick;
      eng_done = 1'b1;
      eng_sig  = SIG_T1;
      #1;
      chk("t1_no_abort", eng_abort, 0);
      tick;
      eng_done = 1'b0;
      eng_sig  = '0;
      chk("t1_rsp_valid", rsp_valid, 1);
      chk("t1_rsp_ch", rsp_ch, 2);
      chk("t1_rsp_err", rsp_err, 0);
      chk("t1_rsp_sig", rsp_sig, SIG_T1);
      chk("t1_key_zero", eng_key, 0);
      rsp_ready = 1'b1;
      tick;
      rsp_ready = 1'b0;
      chk("t1_rsp_gone", rsp_valid, 0);
      chk("t1_idle", busy, 0);
      chk("t1_hash_zero", eng_hash, 0);
      chk("t1_sig_zero", rsp_sig, 0);

      // Reset between jobs returns the pointer to channel 0.
      reset = 1'b1;
      tick;
      reset = 1'b0;
      tick;

      // Round-robin with all channels valid; expected order 0,1,2,3,0,1.
      for (int i = 0; i < NUM_CH; i++) req_key[i*KEY_W +: KEY_W] = key_of(i);
      req_valid = 4'b1111;
      rsp_ready = 1'b1;
      #1;
      for (int j = 0; j < 6; j++) begin
         n = 0;
         while (req_ready === '0 && n < 12) begin
            tick;
            n++;
         end
         chk("rr_grant", req_ready, 4'b0001 << (j % 4));
         tick;
         chk("rr_start", eng_start, 1);
         chk("rr_key", eng_key, key_of(j % 4));
         tick;
         tick;
         eng_done = 1'b1;
         eng_sig  = SIG_W'(j + 100);
         tick;
         eng_done = 1'b0;
         chk("rr_rsp_valid", rsp_valid, 1);
         chk("rr_rsp_ch", rsp_ch, j % 4);
         chk("rr_rsp_sig", rsp_sig, j + 100);
      end
      req_valid = '0;
      tick;
      rsp_ready = 1'b0;

      // eng_done while idle is ignored.
      eng_done = 1'b1;
      tick;
      eng_done = 1'b0;
      chk("stray_done_busy", busy, 0);
      chk("stray_done_rsp", rsp_valid, 0);

      // Partial-shard job on channel 1 (pointer is at 2, so it wraps).
      req_partial = 4'b0010;
      req_key[1*KEY_W +: KEY_W] = KEY_77;
      req_valid = 4'b0010;
      #1;
      chk("p_ready", req_ready, 4'b0010);
      tick;
      req_valid = '0;
      chk("p_start", eng_start, 1);
      chk("p_key", eng_key, KEY_77);
      chk("p_partial_start", eng_partial, 1);
      for (int k = 0; k < 5; k++) begin
         tick;
         chk("p_partial_wait", eng_partial, 1);
      end
      eng_done = 1'b1;
      eng_sig  = SIG_P;
      tick;
      eng_done = 1'b0;
      chk("p_rsp_partial", rsp_partial, 1);
      chk("p_rsp_ch", rsp_ch, 1);
      chk("p_rsp_sig", rsp_sig, SIG_P);
      rsp_ready = 1'b1;
      tick;
      rsp_ready = 1'b0;
      req_partial = '0;

      // Timeout on channel 0: engine never answers.
      req_key[0] = 1'b1;
      req_valid = 4'b0001;
      #1;
      chk("to_ready", req_ready, 4'b0001);
      tick;
      req_valid = '0;
      chk("to_start", eng_start, 1);
      for (int k = 1; k <= 16; k++) begin
         tick;
         chk("to_abort", eng_abort, (k == 16));
      end
      tick;
      chk("to_rsp_valid", rsp_valid, 1);
      chk("to_rsp_err", rsp_err, 1);
      chk("to_rsp_sig", rsp_sig, 0);
      chk("to_abort_pulse", eng_abort, 0);
      chk("to_key_zero", eng_key, 0);
      repeat (3) tick;
      chk("to_busy_hold", busy, 1);
      chk("to_rsp_hold", rsp_valid, 1);
      rsp_ready = 1'b1;
      tick;
      rsp_ready = 1'b0;
      chk("to_idle", busy, 0);

      // Done on the terminal timer cycle: done wins. Channel 3.
      req_valid = 4'b1000;
      #1;
      chk("c_ready", req_ready, 4'b1000);
      tick;
      req_valid = '0;
      chk("c_start", eng_start, 1);
      repeat (16) tick;
      eng_done = 1'b1;
      eng_sig  = SIG_C;
      #1;
      chk("c_no_abort", eng_abort, 0);
      tick;
      eng_done = 1'b0;
      eng_sig  = '0;
      chk("c_rsp_valid", rsp_valid, 1);
      chk("c_rsp_err", rsp_err, 0);
      chk("c_rsp_sig", rsp_sig, SIG_C);

      // Back-pressure: response held 20 cycles while channel 0 waits.
      req_valid = 4'b0001;
      for (int k = 0; k < 20; k++) begin
         tick;
         chk("bp_sig", rsp_sig, SIG_C);
         chk("bp_ctrl", {rsp_valid, rsp_err, rsp_ch, req_ready}, {1'b1, 1'b0, 2'd3, 4'b0000});
      end
      rsp_ready = 1'b1;
      #1;
      chk("bp_no_same_cycle_grant", req_ready, 0);
      tick;
      rsp_ready = 1'b0;
      chk("bp_next_grant", req_ready, 4'b0001);
      tick;
      req_valid = '0;
      chk("rst_job_start", eng_start, 1);
      repeat (4) tick;
      chk("rst_job_waiting", busy, 1);

      // Asynchronous reset mid-WAIT drops the job.
      reset = 1'b1;
      #1;
      chk_all_zero("rst_wait");
      tick;
      reset = 1'b0;
      rsp_ready = 1'b1;
      seen_rsp = 1'b0;
      for (int k = 0; k < 25; k++) begin
         tick;
         seen_rsp = seen_rsp | rsp_valid;
      end
      chk("rst_no_rsp", seen_rsp, 0);
      chk("rst_idle", busy, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/ed25519_sign_dispatch.md
Name: ed25519_sign_dispatch

Overview:
- Parametrised multi-channel front end for the Ed25519 signing datapath.
- Accepts signing requests from NUM_CH clients, each in full-key or partial (threshold shard) mode.
- Round-robin arbitrates requests onto one shared signer engine, supervises the engine with a timeout, and returns a tagged signature or error.
- Holds key material only while a job is in flight and zeroises it afterwards.

Parameters:
- NUM_CH, 4, number of requesting channels (1..16).
- KEY_W, 256, private key / key-shard width.
- HASH_W, 128, message hash width.
- SIG_W, 256, signature width.
- TIMEOUT_CYC, 4096, max cycles waiting for eng_done before abort (must be ≥2).
- CH_W (localparam), max(1, clog2(NUM_CH)).

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- req_valid  in  NUM_CH  per-channel request valid.
- req_ready  out  NUM_CH  per-channel accept; at most one bit high per cycle.
- req_partial  in  NUM_CH  per-channel mode: 1 = partial-shard signing.
- req_key  in  NUM_CH*KEY_W  per-channel key/shard; channel i at [i*KEY_W +: KEY_W].
- req_hash  in  NUM_CH*HASH_W  per-channel hash; same packing.
- eng_start  out  1  one-cycle start pulse to engine.
- eng_partial  out  1  mode to engine, stable from start to done.
- eng_key  out  KEY_W  key to engine, stable from start to done.
- eng_hash  out  HASH_W  hash to engine, stable from start to done.
- eng_abort  out  1  one-cycle pulse on timeout; engine must return to idle.
- eng_done  in  1  engine completion pulse.
- eng_sig  in  SIG_W  engine signature, valid with eng_done.
- rsp_valid  out  1  response valid.
- rsp_ready  in  1  response accept.
- rsp_ch  out  CH_W  originating channel.
- rsp_partial  out  1  mode of the job.
- rsp_sig  out  SIG_W  signature; zero when rsp_err = 1.
- rsp_err  out  1  1 = timeout abort.
- busy  out  1  high in any state except IDLE.

Behaviour:
- Reset: all outputs 0; state IDLE; RR pointer 0; key/hash/sig/timer registers cleared. Reset mid-job drops the job with no response. Engine must also be reset by the top level.
- FSM states: IDLE → ISSUE → WAIT → RESP → IDLE.
- IDLE: if any req_valid, grant the first valid channel at or after the RR pointer, wrapping modulo NUM_CH. In the same cycle:
  - assert req_ready[grant] combinationally (only in IDLE);
  - capture key, hash, partial and channel;
  - set RR pointer = grant+1 (wrap NUM_CH-1 → 0);
  - go to ISSUE.
- A channel never holding valid is skipped. With NUM_CH=1 the pointer stays 0.
- ISSUE: eng_start=1 for exactly one cycle; timer cleared; go to WAIT. eng_key/eng_hash/eng_partial are driven from the captured registers.
- WAIT: timer increments each cycle.
  - eng_done=1: latch eng_sig, rsp_err=0, go to RESP.
  - Else if timer reaches TIMEOUT_CYC-1: eng_abort=1 for one cycle, rsp_sig=0, rsp_err=1, go to RESP.
  - eng_done and timeout in the same cycle: done wins (no abort, no error).
- On leaving WAIT by either path, the captured key register is zeroised in the same cycle. eng_key reads 0 from then on.
- RESP: rsp_valid=1 with rsp_ch/rsp_partial/rsp_sig/rsp_err stable until rsp_ready.
  - On rsp_valid & rsp_ready: rsp_valid→0, rsp_sig zeroised, hash zeroised, go to IDLE.
  - No new grant in that same cycle; earliest next req_ready is the following cycle.
- eng_done outside WAIT is ignored.
- Latency: grant cycle T, eng_start at T+1, rsp_valid the cycle after eng_done. Minimum grant-to-rsp_valid is 3 cycles with eng_done at T+2.
- Requester obligation: hold req_* stable while req_valid is high until req_ready. Deasserting valid without a grant is permitted.

Test Plan:
- Single full job: ch2 valid, partial=0, key=0xA5…A5, hash=0x1234. Expect req_ready[2] that cycle, eng_start next cycle with eng_key=0xA5…A5 and eng_partial=0. Engine returns sig=0xDEAD…BEEF after 10 cycles → rsp_valid, rsp_ch=2, rsp_err=0, rsp_sig=0xDEAD…BEEF; eng_key=0 after done.
- Round-robin fairness: all 4 channels continuously valid, engine done 2 cycles after start, rsp_ready=1. Grant order is 0,1,2,3,0,1; no channel granted twice before all others.
- Partial mode: ch1 partial=1, shard=0x77…77. Expect eng_partial=1 held constant through WAIT, and rsp_partial=1.
- Timeout: TIMEOUT_CYC=16, engine never responds. Expect eng_abort pulse 16 cycles after eng_start, then rsp_err=1, rsp_sig=0, busy=1 until rsp_ready.
- Done/timeout collision: eng_done asserted on the exact terminal timer cycle. Expect rsp_err=0, no eng_abort, signature returned.
- Back-pressure and reset: rsp_ready=0 for 20 cycles. rsp fields stay stable, no new req_ready. Assert reset during WAIT of the next job: all outputs 0 and no response is ever emitted for that job.
